// File: rtl/ram_arbiter_pkg.sv
// rtl/ram_arbiter_pkg.sv - RAM port encodings and defaults shared by the arbiter, RAM and load/store unit
package ram_arbiter_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 8;
  localparam int DEFAULT_DATA_WIDTH = 8;

  localparam logic RAM_RW_READ  = 1'b0;
  localparam logic RAM_RW_WRITE = 1'b1;

  // Increment an index modulo n without a divider.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 == n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - finds the first and second set bits of req scanning from start with wraparound
module rr_pick
  import ram_arbiter_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [IW-1:0] first_idx,
  output logic          first_found,
  output logic [IW-1:0] second_idx,
  output logic          second_found
);

  logic [IW-1:0] idx;

  always_comb begin
    first_idx    = '0;
    first_found  = 1'b0;
    second_idx   = '0;
    second_found = 1'b0;
    idx          = start;
    for (int k = 0; k < N; k++) begin
      if (req[idx]) begin
        if (!first_found) begin
          first_found = 1'b1;
          first_idx   = idx;
        end else if (!second_found) begin
          second_found = 1'b1;
          second_idx   = idx;
        end
      end
      idx = IW'(wrap_inc(32'(idx), N));
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - round-robin arbiter mapping up to two requesters per cycle onto a dual-port RAM
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_REQ    = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rvalid,
  output logic [NUM_REQ*DATA_WIDTH-1:0] rdata,
  output logic                          ram_en,
  output logic [ADDR_WIDTH-1:0]         ram_addr_1,
  output logic [ADDR_WIDTH-1:0]         ram_addr_2,
  output logic [DATA_WIDTH-1:0]         ram_wdata_1,
  output logic [DATA_WIDTH-1:0]         ram_wdata_2,
  output logic                          ram_rw_1,
  output logic                          ram_rw_2,
  input  logic [DATA_WIDTH-1:0]         ram_rdata_1,
  input  logic [DATA_WIDTH-1:0]         ram_rdata_2
);

  localparam int IW = $clog2(NUM_REQ);

  logic [IW-1:0]         rr_ptr;
  logic [IW-1:0]         a_idx, b_idx;
  logic                  a_found, b_found;
  logic [ADDR_WIDTH-1:0] addr_a, addr_b;
  logic                  conflict, b_grant;
  logic                  tag_valid_1, tag_valid_2;
  logic [IW-1:0]         tag_idx_1, tag_idx_2;

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req          (req),
    .start        (rr_ptr),
    .first_idx    (a_idx),
    .first_found  (a_found),
    .second_idx   (b_idx),
    .second_found (b_found)
  );

  assign addr_a = addr[a_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign addr_b = addr[b_idx*ADDR_WIDTH +: ADDR_WIDTH];

  // A same-address pair involving a write is serialised so the RAM never sees read/write overlap.
  assign conflict = (addr_a == addr_b) && (we[a_idx] || we[b_idx]);
  assign b_grant  = a_found && b_found && !conflict;

  always_comb begin
    gnt         = '0;
    ram_addr_1  = '0;
    ram_wdata_1 = '0;
    ram_rw_1    = RAM_RW_READ;
    ram_addr_2  = '0;
    ram_wdata_2 = '0;
    ram_rw_2    = RAM_RW_READ;
    if (a_found) begin
      gnt[a_idx]  = 1'b1;
      ram_addr_1  = addr_a;
      ram_wdata_1 = wdata[a_idx*DATA_WIDTH +: DATA_WIDTH];
      ram_rw_1    = we[a_idx] ? RAM_RW_WRITE : RAM_RW_READ;
    end
    if (b_grant) begin
      gnt[b_idx]  = 1'b1;
      ram_addr_2  = addr_b;
      ram_wdata_2 = wdata[b_idx*DATA_WIDTH +: DATA_WIDTH];
      ram_rw_2    = we[b_idx] ? RAM_RW_WRITE : RAM_RW_READ;
    end
  end

  assign ram_en = |gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      tag_valid_1 <= 1'b0;
      tag_idx_1   <= '0;
      tag_valid_2 <= 1'b0;
      tag_idx_2   <= '0;
    end else begin
      if (a_found) rr_ptr <= IW'(wrap_inc(32'(a_idx), NUM_REQ));
      tag_valid_1 <= a_found && (ram_rw_1 == RAM_RW_READ);
      tag_idx_1   <= a_idx;
      tag_valid_2 <= b_grant && (ram_rw_2 == RAM_RW_READ);
      tag_idx_2   <= b_idx;
    end
  end

  // Tags and RAM output registers are both clocked, so steering them here lands data one cycle after grant.
  always_comb begin
    rvalid = '0;
    rdata  = '0;
    if (tag_valid_1) begin
      rvalid[tag_idx_1]                           = 1'b1;
      rdata[tag_idx_1*DATA_WIDTH +: DATA_WIDTH] = ram_rdata_1;
    end
    if (tag_valid_2) begin
      rvalid[tag_idx_2]                           = 1'b1;
      rdata[tag_idx_2*DATA_WIDTH +: DATA_WIDTH] = ram_rdata_2;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - randomized and directed bench for ram_arbiter against a behavioural arbitration/memory model
module tb_ram_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int N  = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req, we;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    gnt, rvalid;
  logic [N*DW-1:0] rdata;
  logic            ram_en, ram_rw_1, ram_rw_2;
  logic [AW-1:0]   ram_addr_1, ram_addr_2;
  logic [DW-1:0]   ram_wdata_1, ram_wdata_2, ram_rdata_1, ram_rdata_2;

  ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .ram_en(ram_en),
    .ram_addr_1(ram_addr_1), .ram_addr_2(ram_addr_2),
    .ram_wdata_1(ram_wdata_1), .ram_wdata_2(ram_wdata_2),
    .ram_rw_1(ram_rw_1), .ram_rw_2(ram_rw_2),
    .ram_rdata_1(ram_rdata_1), .ram_rdata_2(ram_rdata_2)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input int i);
    return DW'(i * 37 + 11);
  endfunction

  // Dual-port RAM with registered read data
  logic [DW-1:0] ram [256];
  logic          ram_load;

  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
    end else if (ram_en) begin
      if (ram_rw_1) ram[ram_addr_1] <= ram_wdata_1;
      else          ram_rdata_1 <= ram[ram_addr_1];
      if (ram_rw_2) ram[ram_addr_2] <= ram_wdata_2;
      else          ram_rdata_2 <= ram[ram_addr_2];
    end
  end

  // Reference model state
  int            m_ptr;
  logic [DW-1:0] m_mem [256];
  logic [N-1:0]  exp_rvalid;
  logic [DW-1:0] exp_rdata [N];
  int            waitc [N];
  logic [N-1:0]  granted;
  int            checks, errors;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] ga(input int i);
    return addr[i*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] gd(input int i);
    return wdata[i*DW +: DW];
  endfunction

  task automatic drive(input int i, input logic r, input logic w, input logic [AW-1:0] ad, input logic [DW-1:0] wd);
    req[i] = r;
    we[i]  = w;
    addr[i*AW +: AW] = ad;
    wdata[i*DW +: DW] = wd;
  endtask

  task automatic clear_all();
    req = '0; we = '0; addr = '0; wdata = '0;
  endtask

  // One clock: check at negedge against the model, advance the model, return at posedge+1.
  task automatic step();
    int order[$];
    int a, b;
    logic [N-1:0]  eg;
    logic [AW-1:0] ea1, ea2;
    logic [DW-1:0] ed1, ed2;
    logic          er1, er2;
    @(negedge clk);
    for (int k = 0; k < N; k++) if (req[(m_ptr + k) % N]) order.push_back((m_ptr + k) % N);
    a = (order.size() > 0) ? order[0] : -1;
    b = (order.size() > 1) ? order[1] : -1;
    if (b >= 0 && ga(a) == ga(b) && (we[a] || we[b])) b = -1;
    eg = '0; ea1 = '0; ea2 = '0; ed1 = '0; ed2 = '0; er1 = 1'b0; er2 = 1'b0;
    if (a >= 0) begin eg[a] = 1'b1; ea1 = ga(a); ed1 = gd(a); er1 = we[a]; end
    if (b >= 0) begin eg[b] = 1'b1; ea2 = ga(b); ed2 = gd(b); er2 = we[b]; end

    check_eq("gnt", gnt, eg);
    check_eq("ram_en", ram_en, |eg);
    check_eq("addr_1", ram_addr_1, ea1);
    check_eq("wdata_1", ram_wdata_1, ed1);
    check_eq("rw_1", ram_rw_1, er1);
    check_eq("addr_2", ram_addr_2, ea2);
    check_eq("wdata_2", ram_wdata_2, ed2);
    check_eq("rw_2", ram_rw_2, er2);
    check_eq("rvalid", rvalid, exp_rvalid);
    for (int i = 0; i < N; i++)
      if (exp_rvalid[i]) check_eq($sformatf("rdata%0d", i), rdata[i*DW +: DW], exp_rdata[i]);

    granted = eg;
    if (rst_n) begin
      exp_rvalid = '0;
      if (a >= 0 && !we[a]) begin exp_rvalid[a] = 1'b1; exp_rdata[a] = m_mem[ga(a)]; end
      if (b >= 0 && !we[b]) begin exp_rvalid[b] = 1'b1; exp_rdata[b] = m_mem[ga(b)]; end
      if (a >= 0 && we[a]) m_mem[ga(a)] = gd(a);
      if (b >= 0 && we[b]) m_mem[ga(b)] = gd(b);
      if (a >= 0) m_ptr = (a + 1) % N;
      for (int i = 0; i < N; i++) begin
        if (eg[i]) begin
          check_eq($sformatf("starve%0d", i), waitc[i] < N, 1);
          waitc[i] = 0;
        end else if (req[i]) begin
          waitc[i]++;
        end
      end
    end else begin
      m_ptr = 0;
      exp_rvalid = '0;
      for (int i = 0; i < N; i++) waitc[i] = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0; errors = 0; m_ptr = 0; exp_rvalid = '0; granted = '0;
    for (int i = 0; i < N; i++) begin waitc[i] = 0; exp_rdata[i] = '0; end
    for (int i = 0; i < 256; i++) m_mem[i] = init_val(i);
    clear_all();
    ram_load = 1'b1;
    rst_n = 1'b0;
    step();
    ram_load = 1'b0;
    check_eq("rst_rdata", rdata, '0);
    rst_n = 1'b1;

    // Two reads, distinct addresses, from pointer 0
    drive(0, 1'b1, 1'b0, 8'h10, 8'h00);
    drive(1, 1'b1, 1'b0, 8'h20, 8'h00);
    #1 check_eq("plan_gnt01", gnt, 3'b011);
    step();
    clear_all();
    step();

    // Reset while a read is in flight drops its response
    drive(0, 1'b1, 1'b0, 8'h33, 8'h00);
    step();
    clear_all();
    rst_n = 1'b0;
    exp_rvalid = '0;
    step();
    rst_n = 1'b1;

    // Write and read of the same address in one cycle
    drive(0, 1'b1, 1'b1, 8'h40, 8'hA5);
    drive(1, 1'b1, 1'b0, 8'h40, 8'h00);
    #1 check_eq("plan_conflict_gnt", gnt, 3'b001);
    step();
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    step();
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    check_eq("plan_rd_a5", rdata[15:8], 8'hA5);
    step();

    // All three reading continuously from distinct addresses
    for (int c = 0; c < 9; c++) begin
      for (int i = 0; i < N; i++)
        if (granted[i] || !req[i]) drive(i, 1'b1, 1'b0, AW'(8'h80 + c * 3 + i), 8'h00);
      step();
    end
    clear_all();
    step();

    // Single write from requester 2, then read back
    drive(2, 1'b1, 1'b1, 8'h7F, 8'h3C);
    step();
    clear_all();
    drive(0, 1'b1, 1'b0, 8'h7F, 8'h00);
    step();
    clear_all();
    check_eq("plan_rd_3c", rdata[7:0], 8'h3C);
    step();

    // Two reads of the same address
    drive(0, 1'b1, 1'b0, 8'h05, 8'h00);
    drive(1, 1'b1, 1'b0, 8'h05, 8'h00);
    step();
    clear_all();
    step();

    // Random traffic over a small address window to provoke conflicts
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (granted[i] || !req[i])
          drive(i, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                AW'($urandom_range(0, 7)), DW'($urandom));
      step();
    end
    clear_all();
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Round-robin arbiter that shares the two ports of the dual-port byte RAM among up to four requesters (instruction fetch, load/store unit, DMA, debug). Each cycle it grants at most two non-conflicting requests, maps them onto RAM port 1 and port 2, drives the RAM enable, and returns read data to the correct requester one cycle later. It sits between the core/DMA masters and the RAM instance.

## Interface
- ADDR_WIDTH, 8: RAM address width.
- DATA_WIDTH, 8: RAM word width.
- NUM_REQ, 3: number of requesters; legal range 2–4.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  request, one bit per requester.
- we  in  NUM_REQ  1 = write, 0 = read, per requester.
- addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- wdata  in  NUM_REQ*DATA_WIDTH  flattened write data.
- gnt  out  NUM_REQ  grant; combinational from req/we/addr and rr_ptr.
- rvalid  out  NUM_REQ  read data valid, registered.
- rdata  out  NUM_REQ*DATA_WIDTH  read data, registered, per requester.
- ram_en  out  1  RAM enable; equals |gnt.
- ram_addr_1, ram_addr_2  out  ADDR_WIDTH  port addresses.
- ram_wdata_1, ram_wdata_2  out  DATA_WIDTH  port write data.
- ram_rw_1, ram_rw_2  out  1  0 = read, 1 = write.
- ram_rdata_1, ram_rdata_2  in  DATA_WIDTH  RAM registered read outputs.

## Operation
- State: rr_ptr (0..NUM_REQ-1); per-port response tag {valid, requester index}.
- Scan order each cycle starts at rr_ptr and wraps modulo NUM_REQ.
- First requesting index in scan order is winner A and goes to port 1.
- The next requesting index after A is candidate B. It goes to port 2 unless addr_B == addr_A and (we_A | we_B). On that conflict, B is deferred and port 2 stays idle. No further candidates are searched after B.
- An unused port drives rw = 0 and addr/wdata = 0. Its tag is cleared.
- rr_ptr update: if any grant is issued, rr_ptr <= (A+1) mod NUM_REQ. Otherwise rr_ptr holds. Every requester is therefore served within NUM_REQ cycles of continuous request.
- Tag update: for each port, tag <= {granted & ~we, index}. Write grants set no tag.
- Response: for each valid tag, rvalid[idx] = 1 and rdata[idx] = ram_rdata of that port, both registered. A requester receives at most one response per cycle.
- Requester contract: hold req/we/addr/wdata stable until gnt is high; drop or change them the cycle after gnt. Write completes at the grant edge and has no response.
- Reset (async, any time): rr_ptr = 0, tags cleared, rvalid = 0, rdata = 0. In-flight reads are dropped with no rvalid.
- Outputs gnt and ram_* are combinational; after reset with req = 0 they are all 0.

## Timing
- Grant: same cycle as req (0-cycle arbitration). RAM samples at the rising edge closing cycle N.
- Read latency: req/gnt in cycle N, then rvalid/rdata in cycle N+1. Back-to-back reads by one requester give rvalid every cycle.
- Write: visible to a read granted in cycle N+1 or later.
- Same-cycle read and write to one address never occur, because the conflict rule defers the second request.
- rr_ptr and tags change only on rising clk or on falling rst_n.

## Structure
- Shared package/header: RAM_RW_READ = 0, RAM_RW_WRITE = 1, default ADDR_WIDTH/DATA_WIDTH. These are shared with the RAM and the load/store unit.
- One sub-module, rr_pick: given req vector and start pointer, returns first and second set indices plus found flags. It is purely combinational and instanced once.
- Response tags and rdata registers live in ram_arbiter.

## Test plan
- Reset, all req = 0: gnt = 0, ram_en = 0, rvalid = 0. Assert rst_n mid-read: no rvalid the following cycle.
- req0 read 0x10 and req1 read 0x20, rr_ptr = 0: gnt = 3'b011, port1 addr 0x10, port2 addr 0x20. Next cycle rvalid = 3'b011 with the preloaded values.
- req0 write 0x40 = 0xA5 and req1 read 0x40 in the same cycle: only gnt0. Next cycle gnt1, and a cycle later rdata1 = 0xA5.
- All three reading continuously from distinct addresses: grant pairs rotate {0,1}, {1,2}, {2,0}, ... No requester waits more than 3 cycles.
- req2 only, write 0x7F = 0x3C: port1 rw = 1, port 2 idle, rvalid stays 0. A later read of 0x7F returns 0x3C.
- Two reads of the same address 0x05 in one cycle: both granted (no write, so no conflict). Next cycle both rvalid with the same data.
